// File: rtl/pool2x2_stream_if.sv
// Stream bundle for pool2x2_stream: input pixel stream (m_*) with its config, output stream (s_*).
// slave = pooling block view; master = producer/consumer environment view.
// Ports: m_data/m_valid/m_ready/m_width/m_mode in, s_data/s_valid/s_ready/s_last out.
interface pool2x2_stream_if #(
    parameter int DW = 8,
    parameter int DN = 6,
    parameter int CW = 6
) ();
    logic [DN*DW-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic [CW-1:0]    m_width;
    logic [1:0]       m_mode;
    logic [DN*DW-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic             s_last;

    modport slave (
        input  m_data, m_valid, m_width, m_mode, s_ready,
        output m_ready, s_data, s_valid, s_last
    );

    modport master (
        output m_data, m_valid, m_width, m_mode, s_ready,
        input  m_ready, s_data, s_valid, s_last
    );
endinterface

// File: rtl/pool2x2_stream.sv
// 2x2 stride-2 max/average pooling over DN parallel channels; bypass passes beats straight through.
// Latency: 1 cycle from accepted beat (bypass) or from the 4th pixel of a 2x2 window to s_valid.
// Backpressure: m_ready = ~s_valid | s_ready; output register holds while s_valid & ~s_ready.
// Ports: clk, rst (sync, active-high), bus (slave modport: m_* input stream + config, s_* output).
module pool2x2_stream #(
    parameter int DW    = 8,
    parameter int DN    = 6,
    parameter int MAX_W = 32,
    parameter int CW    = 6
) (
    input  logic              clk,
    input  logic              rst,
    pool2x2_stream_if.slave   bus
);
    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int BW = DW + 1;                 // line buffer keeps a full pair sum per channel
    localparam logic [CW-1:0] MAX_W_C = CW'(MAX_W);

    logic [1:0]       cfg_mode;
    logic [CW-1:0]    cfg_w;
    logic             h;                        // 0: first pixel of pair, 1: second
    logic [CW-1:0]    col;
    logic             row;                      // 0: top row of the pair, 1: bottom row
    logic [DN*DW-1:0] p0;

    logic [DN*BW-1:0] line_buf [MAX_W];
    logic [DN*BW-1:0] buf_rd;
    logic [DN*BW-1:0] pair_val;
    logic [DN*DW-1:0] pool_out;

    logic             bypass;
    logic             avg_mode;
    logic             idle;
    logic             accept;
    logic             col_last;
    logic [AW-1:0]    col_idx;
    logic             produce;

    assign bypass   = (cfg_mode == 2'd0);
    assign avg_mode = (cfg_mode == 2'd2);      // mode 3 falls back to max
    assign idle     = ~h & (col == '0) & ~row;
    assign col_last = (col == cfg_w - 1'b1);
    assign col_idx  = col[AW-1:0];
    assign buf_rd   = line_buf[col_idx];

    assign bus.m_ready = ~bus.s_valid | bus.s_ready;
    assign accept      = bus.m_valid & bus.m_ready;
    assign produce     = accept & (bypass | (h & row));

    // Per-channel arithmetic; channels never interact.
    for (genvar k = 0; k < DN; k++) begin : g_ch
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] hmax;
        logic [DW:0]   hsum;
        logic [DW:0]   lb;
        logic [DW-1:0] vmax;

        assign a    = p0[k*DW +: DW];
        assign b    = bus.m_data[k*DW +: DW];
        assign hmax = (a > b) ? a : b;
        assign hsum = {1'b0, a} + {1'b0, b};
        assign lb   = buf_rd[k*BW +: BW];
        assign vmax = (lb[DW-1:0] > hmax) ? lb[DW-1:0] : hmax;

        assign pair_val[k*BW +: BW] = avg_mode ? hsum : {1'b0, hmax};
        // Four-pixel sum fits in DW+2 bits; +2 gives round-half-up, result never exceeds 2^DW-1.
        assign pool_out[k*DW +: DW] = avg_mode
            ? DW'(({1'b0, lb} + {1'b0, hsum} + (DW+2)'(2)) >> 2)
            : vmax;
    end

    // Line buffer is written before it is read in every row pair, so it carries no reset.
    always_ff @(posedge clk) begin
        if (!rst && accept && !bypass && h && !row) begin
            line_buf[col_idx] <= pair_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_mode    <= 2'd0;
            cfg_w       <= CW'(1);
            h           <= 1'b0;
            col         <= '0;
            row         <= 1'b0;
            p0          <= '0;
            bus.s_valid <= 1'b0;
            bus.s_last  <= 1'b0;
            bus.s_data  <= '0;
        end else begin
            // Config only tracks the inputs between row pairs.
            if (idle) begin
                cfg_mode <= bus.m_mode;
                cfg_w    <= (bus.m_width == '0 || bus.m_width > MAX_W_C) ? MAX_W_C : bus.m_width;
            end

            if (accept && !bypass) begin
                if (!h) begin
                    p0 <= bus.m_data;
                end
                h <= ~h;
                if (h) begin
                    if (col_last) begin
                        col <= '0;
                        row <= ~row;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end

            // A new result may replace one being consumed in the same cycle.
            if (produce) begin
                bus.s_valid <= 1'b1;
                bus.s_data  <= bypass ? bus.m_data : pool_out;
                bus.s_last  <= ~bypass & col_last;
            end else if (bus.s_ready) begin
                bus.s_valid <= 1'b0;
                bus.s_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pool2x2_stream.sv
// Self-checking bench for pool2x2_stream: directed row pairs plus randomized data and backpressure,
// scored against a reference that pools whole row pairs with plain integer arithmetic.
// Inputs driven after the falling edge, outputs sampled just before the rising edge.
module tb_pool2x2_stream;
    localparam int DW    = 8;
    localparam int DN    = 6;
    localparam int MAX_W = 32;
    localparam int CW    = 6;
    localparam int NB    = DN * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pool2x2_stream_if #(.DW(DW), .DN(DN), .CW(CW)) bus ();

    pool2x2_stream #(.DW(DW), .DN(DN), .MAX_W(MAX_W), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [NB-1:0] pix [4*MAX_W];
    logic [NB-1:0] exp_d [$];
    logic          exp_l [$];

    int dir1a [8]  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h05, 8'h0A};
    int dir1b [12] = '{8'h06, 8'h04, 8'h01, 8'h05, 8'h04, 8'h01,
                       8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11};
    int dir2  [12] = '{8'h01, 8'h02, 8'h03, 8'h06, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                       8'h00, 8'h00, 8'h00, 8'h02};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [NB-1:0] rep(input logic [7:0] b);
        return {DN{b}};
    endfunction

    function automatic logic rnd_rdy(input int pct);
        if (pct >= 100) return 1'b1;
        return ($urandom_range(0, 99) < pct);
    endfunction

    function automatic int eff_w(input int wraw);
        return (wraw == 0 || wraw > MAX_W) ? MAX_W : wraw;
    endfunction

    // One clock: score any output handed over this cycle, report whether the input beat was taken.
    task automatic step(output bit in_fire);
        #1;
        in_fire = bus.m_valid && bus.m_ready;
        if (bus.s_valid && bus.s_ready) begin
            if (exp_d.size() == 0) begin
                chk("extra_out", 64'(exp_d.size()), 64'd1);
            end else begin
                chk("out_data", 64'(bus.s_data), 64'(exp_d.pop_front()));
                chk("out_last", 64'(bus.s_last), 64'(exp_l.pop_front()));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick();
        bit f;
        step(f);
    endtask

    task automatic send_pix(input logic [NB-1:0] v, input int pct);
        bit f;
        f = 1'b0;
        bus.m_valid = 1'b1;
        bus.m_data  = v;
        for (int t = 0; t < 200 && !f; t++) begin
            bus.s_ready = rnd_rdy(pct);
            step(f);
        end
        if (!f) chk("in_accept", 64'(f), 64'd1);
        bus.m_valid = 1'b0;
    endtask

    // Reference: pool a complete row pair held in pix[] (top row then bottom row).
    task automatic model_pair(input int mode, input int wraw);
        int w;
        w = eff_w(wraw);
        if (mode == 0) begin
            for (int i = 0; i < 4*w; i++) begin
                exp_d.push_back(pix[i]);
                exp_l.push_back(1'b0);
            end
        end else begin
            for (int c = 0; c < w; c++) begin
                logic [NB-1:0] o;
                o = '0;
                for (int k = 0; k < DN; k++) begin
                    int v [4];
                    int r;
                    v[0] = int'(pix[2*c][k*DW +: DW]);
                    v[1] = int'(pix[2*c+1][k*DW +: DW]);
                    v[2] = int'(pix[2*w+2*c][k*DW +: DW]);
                    v[3] = int'(pix[2*w+2*c+1][k*DW +: DW]);
                    if (mode == 2) begin
                        r = (v[0] + v[1] + v[2] + v[3] + 2) / 4;
                    end else begin
                        r = v[0];
                        for (int j = 1; j < 4; j++) if (v[j] > r) r = v[j];
                    end
                    o[k*DW +: DW] = DW'(r);
                end
                exp_d.push_back(o);
                exp_l.push_back(c == w - 1);
            end
        end
    endtask

    // tog >= 0: switch m_mode/m_width to tmode/tw just before pixel tog (mid row pair).
    task automatic send_pair(input int mode, input int wraw, input int pct,
                             input int tog, input int tmode, input int tw);
        model_pair(mode, wraw);
        for (int i = 0; i < 4*eff_w(wraw); i++) begin
            if (i == tog) begin
                bus.m_mode  = 2'(tmode);
                bus.m_width = CW'(tw);
            end
            send_pix(pix[i], pct);
        end
    endtask

    task automatic set_cfg(input int mode, input int w);
        bus.m_mode  = 2'(mode);
        bus.m_width = CW'(w);
        bus.m_valid = 1'b0;
        bus.s_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic drain();
        bus.m_valid = 1'b0;
        bus.s_ready = 1'b1;
        for (int t = 0; t < 300 && exp_d.size() > 0; t++) tick();
        tick();
        tick();
        chk("drain_left", 64'(exp_d.size()), 64'd0);
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) pix[i] = NB'({$urandom(), $urandom()});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [NB-1:0] held;
        logic [NB-1:0] first;
        int m;
        int w;

        bus.m_data  = '0;
        bus.m_valid = 1'b0;
        bus.m_width = CW'(1);
        bus.m_mode  = 2'd0;
        bus.s_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_s_valid", 64'(bus.s_valid), 64'd0);
        chk("rst_s_last",  64'(bus.s_last),  64'd0);
        chk("rst_s_data",  64'(bus.s_data),  64'd0);
        chk("rst_m_ready", 64'(bus.m_ready), 64'd1);
        rst = 1'b0;

        // Max, width 2 then width 3.
        set_cfg(1, 2);
        for (int i = 0; i < 8; i++) pix[i] = rep(8'(dir1a[i]));
        send_pair(1, 2, 100, -1, 0, 0);
        drain();
        set_cfg(1, 3);
        for (int i = 0; i < 12; i++) pix[i] = rep(8'(dir1b[i]));
        send_pair(1, 3, 100, -1, 0, 0);
        drain();

        // Average, width 1: plain, saturating inputs, rounding.
        set_cfg(2, 1);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 4; i++) pix[i] = rep(8'(dir2[4*p+i]));
            send_pair(2, 1, 100, -1, 0, 0);
        end
        drain();

        // Output stalled: input must be refused and the output frozen.
        set_cfg(1, 1);
        fill_rand(4);
        send_pair(1, 1, 0, -1, 0, 0);
        held = bus.s_data;
        bus.m_valid = 1'b1;
        bus.m_data  = rep(8'h5A);
        bus.s_ready = 1'b0;
        for (int t = 0; t < 3; t++) begin
            #1;
            chk("bp_m_ready", 64'(bus.m_ready), 64'd0);
            chk("bp_s_valid", 64'(bus.s_valid), 64'd1);
            chk("bp_hold",    64'(bus.s_data),  64'(held));
            @(posedge clk);
            @(negedge clk);
        end
        bus.m_valid = 1'b0;
        drain();

        // 64 outputs of max pooling under 50% random output backpressure.
        set_cfg(1, 8);
        for (int p = 0; p < 8; p++) begin
            fill_rand(32);
            send_pair(1, 8, 50, -1, 0, 0);
        end
        drain();

        // Bypass with gaps: each beat visible one cycle after acceptance.
        set_cfg(0, 1);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] v;
            v = (i < 3) ? 8'(i + 1) : 8'(i + 3);
            if (i == 3) begin
                tick();
                tick();
                chk("byp_gap_valid", 64'(bus.s_valid), 64'd0);
            end
            exp_d.push_back(rep(v));
            exp_l.push_back(1'b0);
            send_pix(rep(v), 100);
            chk("byp_valid", 64'(bus.s_valid), 64'd1);
            chk("byp_data",  64'(bus.s_data),  64'(rep(v)));
            chk("byp_last",  64'(bus.s_last),  64'd0);
        end
        drain();

        // Config changes inside a row pair are ignored.
        set_cfg(2, 2);
        fill_rand(8);
        send_pair(2, 2, 100, 3, 1, 1);
        drain();
        set_cfg(1, 1);
        fill_rand(4);
        send_pair(1, 1, 100, 1, 2, 5);
        drain();

        // Reset with an output pending and a partial pair.
        set_cfg(1, 2);
        fill_rand(8);
        model_pair(1, 2);
        first = exp_d[0];
        exp_d.delete();
        exp_l.delete();
        for (int i = 0; i < 6; i++) send_pix(pix[i], 0);
        chk("pre_rst_valid", 64'(bus.s_valid), 64'd1);
        chk("pre_rst_data",  64'(bus.s_data),  64'(first));
        rst = 1'b1;
        bus.s_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", 64'(bus.s_valid), 64'd0);
        chk("mid_rst_data",  64'(bus.s_data),  64'd0);
        chk("mid_rst_last",  64'(bus.s_last),  64'd0);
        set_cfg(1, 1);
        fill_rand(3);
        for (int i = 0; i < 3; i++) send_pix(pix[i], 100);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        set_cfg(1, 1);
        fill_rand(4);
        send_pair(1, 1, 100, -1, 0, 0);
        drain();

        // Out-of-range widths fall back to MAX_W.
        set_cfg(1, 0);
        fill_rand(4*MAX_W);
        send_pair(1, 0, 80, -1, 0, 0);
        drain();
        set_cfg(2, MAX_W + 5);
        fill_rand(4*MAX_W);
        send_pair(2, MAX_W + 5, 80, -1, 0, 0);
        drain();

        // Random configurations, including reserved mode 3 and bypass.
        for (int r = 0; r < 6; r++) begin
            m = $urandom_range(1, 3);
            w = $urandom_range(1, 6);
            set_cfg(m, w);
            for (int p = 0; p < 2; p++) begin
                fill_rand(4*w);
                send_pair(m, w, $urandom_range(30, 100), -1, 0, 0);
            end
            drain();
        end
        set_cfg(0, 2);
        fill_rand(8);
        send_pair(0, 2, 60, -1, 0, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
